// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control unit FSM
//
// Purpose: sequences lw, sw, R-type, addi, beq, j (and optionally the DSP
// QB add instructions) through a Harris/Harris-style multicycle datapath.
//
// Optional feature: define DSP_QB_EN to enable the Op=0x1F DSP path
// (ADDU.QB / ADDU_S.QB via the DSPEXEC state). Without it Op=0x1F is illegal.
//
// Parameters:
//   FETCH_WAIT  extra FETCH cycles for slow instruction memory (0..15)
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   Op, Funct, Shamt  instruction fields [31:26], [5:0], [10:6]
//   Zero              ALU zero flag (used for beq)
//   IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
//   PCWrite, Branch   datapath controls decoded from the state register
//   ALUSrcB, PCSrc    2-bit mux selects
//   ALUControl        4-bit ALU operation
//   PCEn              PC load enable = PCWrite | (Branch & Zero)
//   Illegal           unsupported Op/Funct/Shamt in the decoding state
//   State             current state (debug)

module mips_multicycle_ctrl #(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic [4:0] Shamt,
  input  logic       Zero,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUControl,
  output logic       PCWrite,
  output logic       Branch,
  output logic       PCEn,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_DSPEXEC  = 4'd12;

  localparam logic [3:0] ALU_AND    = 4'd0;
  localparam logic [3:0] ALU_OR     = 4'd1;
  localparam logic [3:0] ALU_ADD    = 4'd2;
  localparam logic [3:0] ALU_XOR    = 4'd3;
  localparam logic [3:0] ALU_SUB    = 4'd6;
  localparam logic [3:0] ALU_SLT    = 4'd7;
  localparam logic [3:0] ALU_ADDUQB = 4'd8;
  localparam logic [3:0] ALU_ADDUSQB = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_DSP   = 6'h1F;

  localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

  logic [3:0] state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       fetch_done;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic       dsp_ok;
  logic [3:0] dsp_alu;

  // Instruction fetch completes on the last FETCH cycle; only then are the
  // IR and PC loaded.
  assign fetch_done = (state_q == S_FETCH) && (wait_q == WAIT_LAST);
  assign State      = state_q;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h26:   funct_alu = ALU_XOR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

`ifdef DSP_QB_EN
  always_comb begin
    dsp_ok  = 1'b0;
    dsp_alu = ALU_ADD;
    if (Funct == 6'h10) begin
      if (Shamt == 5'd0) begin
        dsp_ok  = 1'b1;
        dsp_alu = ALU_ADDUQB;
      end else if (Shamt == 5'd4) begin
        dsp_ok  = 1'b1;
        dsp_alu = ALU_ADDUSQB;
      end
    end
  end
`else
  assign dsp_ok  = 1'b0;
  assign dsp_alu = ALU_ADD;
  logic unused_dsp;
  assign unused_dsp = ^{Shamt, dsp_ok, dsp_alu, ALU_ADDUQB, ALU_ADDUSQB, OP_DSP};
`endif

  // Next-state logic. The wait counter only advances inside FETCH and is
  // zero everywhere else, so it is already clear on every entry to FETCH.
  always_comb begin
    state_d = state_q;
    wait_d  = 4'd0;
    case (state_q)
      S_FETCH: begin
        if (fetch_done) state_d = S_DECODE;
        else            wait_d  = wait_q + 4'd1;
      end
      S_DECODE: begin
        case (Op)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEXEC;
          OP_J:          state_d = S_JUMP;
`ifdef DSP_QB_EN
          OP_DSP:        state_d = S_DSPEXEC;
`endif
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = funct_ok ? S_ALUWB : S_FETCH;
      S_DSPEXEC:  state_d = dsp_ok ? S_ALUWB : S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Output decode. Illegal and ALUControl also look at the instruction
  // fields; everything else depends only on the registered state.
  always_comb begin
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = ALU_AND;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    Illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        IRWrite    = fetch_done;
        PCWrite    = fetch_done;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
        case (Op)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: Illegal = 1'b0;
`ifdef DSP_QB_EN
          OP_DSP:  Illegal = 1'b0;
`endif
          default: Illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        Illegal    = ~funct_ok;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        Branch     = 1'b1;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      S_DSPEXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = dsp_alu;
        Illegal    = ~dsp_ok;
      end
      default: ;
    endcase
    // No architectural write may escape while reset is held.
    if (reset) begin
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      PCWrite  = 1'b0;
    end
    PCEn = (PCWrite | (Branch & Zero)) & ~reset;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl

module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic [4:0] Shamt;
  logic       Zero;

  logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUControl, State;
  logic       PCWrite, Branch, PCEn, Illegal;

  logic       w_IorD, w_IRWrite, w_MemWrite, w_RegWrite, w_RegDst, w_MemtoReg, w_ALUSrcA;
  logic [1:0] w_ALUSrcB, w_PCSrc;
  logic [3:0] w_ALUControl, w_State;
  logic       w_PCWrite, w_Branch, w_PCEn, w_Illegal;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.FETCH_WAIT(0)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Shamt(Shamt), .Zero(Zero),
    .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .ALUControl(ALUControl), .PCWrite(PCWrite), .Branch(Branch),
    .PCEn(PCEn), .Illegal(Illegal), .State(State)
  );

  mips_multicycle_ctrl #(.FETCH_WAIT(3)) dut_w (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Shamt(Shamt), .Zero(Zero),
    .IorD(w_IorD), .IRWrite(w_IRWrite), .MemWrite(w_MemWrite), .RegWrite(w_RegWrite),
    .RegDst(w_RegDst), .MemtoReg(w_MemtoReg), .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB),
    .PCSrc(w_PCSrc), .ALUControl(w_ALUControl), .PCWrite(w_PCWrite), .Branch(w_Branch),
    .PCEn(w_PCEn), .Illegal(w_Illegal), .State(w_State)
  );

  // One instruction: inputs, cycle count, expected state per cycle (nibble i
  // of seq), and the single cycle index (or -1) where each strobe is high.
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] shamt;
    logic       zero;
    int         n;
    logic [23:0] seq;
    int         alu;
    int         wr;
    int         rd;
    int         mw;
    int         mtr;
    int         pcen;
    int         ill;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic void add(input string name, input logic [5:0] op, input logic [5:0] funct,
                              input logic [4:0] shamt, input logic zero, input int n,
                              input logic [23:0] seq, input int alu, input int wr, input int rd,
                              input int mw, input int mtr, input int pcen, input int ill);
    vec_t v;
    v.name = name; v.op = op; v.funct = funct; v.shamt = shamt; v.zero = zero;
    v.n = n; v.seq = seq; v.alu = alu; v.wr = wr; v.rd = rd; v.mw = mw;
    v.mtr = mtr; v.pcen = pcen; v.ill = ill;
    vecs.push_back(v);
  endfunction

  initial begin
    //   name        op     funct  sh  z  n  seq        alu wr  rd  mw  mtr pcen ill
    add("lw",       6'h23, 6'h00, 0, 0, 5, 24'h043210,  2,  4, -1, -1,  4, -1, -1);
    add("sw",       6'h2B, 6'h00, 0, 0, 4, 24'h005210,  2, -1, -1,  3, -1, -1, -1);
    add("sub",      6'h00, 6'h22, 0, 0, 4, 24'h007610,  6,  3,  3, -1, -1, -1, -1);
    add("add",      6'h00, 6'h20, 0, 0, 4, 24'h007610,  2,  3,  3, -1, -1, -1, -1);
    add("and",      6'h00, 6'h24, 0, 0, 4, 24'h007610,  0,  3,  3, -1, -1, -1, -1);
    add("or",       6'h00, 6'h25, 0, 0, 4, 24'h007610,  1,  3,  3, -1, -1, -1, -1);
    add("xor",      6'h00, 6'h26, 0, 0, 4, 24'h007610,  3,  3,  3, -1, -1, -1, -1);
    add("slt",      6'h00, 6'h2A, 0, 0, 4, 24'h007610,  7,  3,  3, -1, -1, -1, -1);
    add("badfunct", 6'h00, 6'h3F, 0, 0, 3, 24'h000610, -1, -1, -1, -1, -1, -1,  2);
    add("addi",     6'h08, 6'h00, 0, 0, 4, 24'h00A910,  2,  3, -1, -1, -1, -1, -1);
    add("beq_t",    6'h04, 6'h00, 0, 1, 3, 24'h000810,  6, -1, -1, -1, -1,  2, -1);
    add("beq_nt",   6'h04, 6'h00, 0, 0, 3, 24'h000810,  6, -1, -1, -1, -1, -1, -1);
    add("j",        6'h02, 6'h00, 0, 0, 3, 24'h000B10,  0, -1, -1, -1, -1,  2, -1);
    add("badop",    6'h3F, 6'h00, 0, 0, 2, 24'h000010, -1, -1, -1, -1, -1, -1,  1);
`ifdef DSP_QB_EN
    add("addus_qb", 6'h1F, 6'h10, 4, 0, 4, 24'h007C10,  9,  3,  3, -1, -1, -1, -1);
    add("addu_qb",  6'h1F, 6'h10, 0, 0, 4, 24'h007C10,  8,  3,  3, -1, -1, -1, -1);
    add("dsp_bad",  6'h1F, 6'h10, 1, 0, 3, 24'h000C10, -1, -1, -1, -1, -1, -1,  2);
`else
    add("dsp_off",  6'h1F, 6'h10, 4, 0, 2, 24'h000010, -1, -1, -1, -1, -1, -1,  1);
`endif

    Op = 6'h00; Funct = 6'h00; Shamt = 5'd0; Zero = 1'b0;
    reset = 1'b1;
    step();
    step();

    // Reset state and strobe suppression while reset is held.
    chk("reset.State", State, 0);
    chk("reset.IRWrite", IRWrite, 0);
    chk("reset.PCWrite", PCWrite, 0);
    chk("reset.PCEn", PCEn, 0);
    chk("reset.w_State", w_State, 0);
    reset = 1'b0;

    // Table of single instructions, chained back to back at FETCH_WAIT=0.
    foreach (vecs[k]) begin
      Op = vecs[k].op; Funct = vecs[k].funct; Shamt = vecs[k].shamt; Zero = vecs[k].zero;
      #1;
      for (int i = 0; i < vecs[k].n; i++) begin
        chk($sformatf("%s.c%0d.State", vecs[k].name, i), State, int'(vecs[k].seq[i*4 +: 4]));
        chk($sformatf("%s.c%0d.RegWrite", vecs[k].name, i), RegWrite, int'(i == vecs[k].wr));
        chk($sformatf("%s.c%0d.RegDst", vecs[k].name, i), RegDst, int'(i == vecs[k].rd));
        chk($sformatf("%s.c%0d.MemWrite", vecs[k].name, i), MemWrite, int'(i == vecs[k].mw));
        chk($sformatf("%s.c%0d.MemtoReg", vecs[k].name, i), MemtoReg, int'(i == vecs[k].mtr));
        chk($sformatf("%s.c%0d.PCEn", vecs[k].name, i), PCEn, int'(i == 0 || i == vecs[k].pcen));
        chk($sformatf("%s.c%0d.Illegal", vecs[k].name, i), Illegal, int'(i == vecs[k].ill));
        if (i == 2 && vecs[k].alu >= 0)
          chk($sformatf("%s.ALUControl", vecs[k].name), ALUControl, vecs[k].alu);
        step();
      end
      chk($sformatf("%s.end.State", vecs[k].name), State, 0);
    end

    // FETCH_WAIT=3: four FETCH cycles, IR loaded only in the fourth.
    Op = 6'h02; Funct = 6'h00; Shamt = 5'd0; Zero = 1'b0;
    do_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wait.c%0d.State", i), w_State, 0);
      chk($sformatf("wait.c%0d.IRWrite", i), w_IRWrite, int'(i == 3));
      chk($sformatf("wait.c%0d.PCEn", i), w_PCEn, int'(i == 3));
      step();
    end
    chk("wait.decode.State", w_State, 1);
    step();
    chk("wait.jump.State", w_State, 11);
    chk("wait.jump.PCEn", w_PCEn, 1);
    step();
    chk("wait.back.State", w_State, 0);
    chk("wait.back.IRWrite", w_IRWrite, 0);

    // Reset asserted in MEMWR kills the store and returns to FETCH.
    Op = 6'h2B;
    do_reset();
    step();
    step();
    step();
    chk("rstmid.State", State, 5);
    chk("rstmid.MemWrite.before", MemWrite, 1);
    reset = 1'b1;
    #1;
    chk("rstmid.MemWrite", MemWrite, 0);
    chk("rstmid.PCEn", PCEn, 0);
    step();
    chk("rstmid.next.State", State, 0);
    reset = 1'b0;
    #1;
    chk("rstmid.fetch.IRWrite", IRWrite, 1);

    // Reset in the middle of a long FETCH clears the wait counter.
    Op = 6'h02;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstwait.c%0d.IRWrite", i), w_IRWrite, int'(i == 3));
      step();
    end
    chk("rstwait.decode.State", w_State, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter: FETCH_WAIT, default 0, number of extra FETCH cycles inserted for slow instruction memory (0..15).
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Op  input  6  instruction[31:26].
REQ-005 Funct  input  6  instruction[5:0].
REQ-006 Shamt  input  5  instruction[10:6]; selects the QB sub-operation.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 Outputs, 1 bit each: IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, PCWrite, Branch, PCEn, Illegal.
REQ-009 ALUSrcB and PCSrc, output, 2 bits each; ALUControl, output, 4 bits; State, output, 4 bits (debug).

Function
REQ-010 ALUControl encoding: AND=0, OR=1, ADD=2, XOR=3, SUB=6, SLT=7, ADDU.QB=8, ADDU_S.QB=9.
REQ-011 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, DSPEXEC=12.
REQ-012 Transitions: FETCH->DECODE after wait; DECODE by Op: 0x00->EXECUTE, 0x23/0x2B->MEMADR, 0x04->BRANCH, 0x08->ADDIEXEC, 0x02->JUMP, 0x1F->DSPEXEC.
REQ-013 Transitions: MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; EXECUTE->ALUWB; DSPEXEC->ALUWB; ADDIEXEC->ADDIWB.
REQ-014 Transitions: MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP all return to FETCH.
REQ-015 Unsupported Op in DECODE: Illegal=1 that cycle, next state FETCH, no write strobe asserted.
REQ-016 FETCH outputs: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=00; IRWrite=PCWrite=1 only on the final FETCH cycle.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ADD.
REQ-018 MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ADD.
REQ-019 MEMRD: IorD=1. MEMWR: IorD=1, MemWrite=1. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
REQ-020 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
REQ-021 EXECUTE: ALUSrcA=1, ALUSrcB=00; Funct 0x20->ADD, 0x22->SUB, 0x24->AND, 0x25->OR, 0x26->XOR, 0x2A->SLT.
REQ-022 EXECUTE with any other Funct: Illegal=1, next state FETCH, RegWrite suppressed.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, Branch=1. JUMP: PCSrc=10, PCWrite=1.
REQ-024 PCEn = PCWrite | (Branch & Zero), combinational, same cycle as its inputs.
REQ-025 Outputs not listed for a state are 0; all outputs are decoded from the state register only, except PCEn, Illegal and ALUControl.
REQ-026 FETCH wait counter: cleared on entering FETCH, increments each FETCH cycle; exit when count==FETCH_WAIT; FETCH_WAIT=0 gives a one-cycle FETCH.
REQ-027 Cycle counts at FETCH_WAIT=0: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-028 reset high at a clock edge: State=FETCH, wait counter=0, regardless of the current state, including mid-instruction.
REQ-029 While reset is high, MemWrite, RegWrite, IRWrite, PCWrite and PCEn are forced to 0.

Configuration
REQ-030 Macro DSP_QB_EN.
REQ-031 DSP_QB_EN defined: in DSPEXEC with Funct=0x10, Shamt 0->ADDU.QB (8) and Shamt 4->ADDU_S.QB (9); ALUSrcA=1, ALUSrcB=00.
REQ-032 DSP_QB_EN defined, any other Funct/Shamt in DSPEXEC: Illegal=1, return to FETCH.
REQ-033 DSP_QB_EN undefined: Op 0x1F is illegal in DECODE, and DSPEXEC is unreachable.

Verification
REQ-034 lw, Op=0x23, FETCH_WAIT=0 -> State 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4.
REQ-035 R-type, Funct=0x22 -> ALUControl=6 in EXECUTE; RegDst=1, RegWrite=1 in ALUWB.
REQ-036 beq, Op=0x04: Zero=1 -> PCEn=1 in BRANCH; Zero=0 -> PCEn=0.
REQ-037 FETCH_WAIT=3 -> 4 FETCH cycles; IRWrite=1 only in the 4th.
REQ-038 Op=0x1F, Funct=0x10, Shamt=4 -> ALUControl=9 with DSP_QB_EN; Illegal=1 in DECODE without it; Op=0x3F -> Illegal=1 in DECODE.
REQ-039 reset asserted in MEMWR -> MemWrite=0 that cycle, State=0 next cycle.
